// File: rtl/exe_stage_if.sv
// ID->EXE->MEM pipeline handshake, forwarding bus and data SRAM request port
// of the execute stage.
interface exe_stage_if;
  logic         ID_to_EXE_valid;
  logic         EXE_allow_in;
  logic [186:0] ID_to_EXE_bus;
  logic         MEM_allow_in;
  logic         EXE_to_MEM_valid;
  logic [70:0]  EXE_to_MEM_bus;
  logic [38:0]  EXE_wr_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  modport slave (
    input  ID_to_EXE_valid, ID_to_EXE_bus, MEM_allow_in,
    output EXE_allow_in, EXE_to_MEM_valid, EXE_to_MEM_bus, EXE_wr_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport master (
    output ID_to_EXE_valid, ID_to_EXE_bus, MEM_allow_in,
    input  EXE_allow_in, EXE_to_MEM_valid, EXE_to_MEM_bus, EXE_wr_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU and multiplier, 33-cycle radix-2 divider,
// store request generation and forwarding/hazard bus back to ID.
module exe_stage (
  input  logic       clk,
  input  logic       resetn,
  exe_stage_if.slave pipe
);

  typedef struct packed {
    logic [18:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        res_from_mem;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] rkd_value;
    logic [31:0] pc;
    logic [31:0] inst;
  } id_exe_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  id_exe_t     r;
  logic        exe_valid;
  logic        exe_ready_go;
  logic        allow_in;
  logic [31:0] exe_result;
  logic        unused_inst;

  assign allow_in    = ~exe_valid | (exe_ready_go & pipe.MEM_allow_in);
  assign unused_inst = ^r.inst;

  always_ff @(posedge clk) begin
    if (!resetn)       exe_valid <= 1'b0;
    else if (allow_in) exe_valid <= pipe.ID_to_EXE_valid;
  end

  // NOTE: the payload register has no reset; exe_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (pipe.ID_to_EXE_valid && allow_in) r <= pipe.ID_to_EXE_bus;
  end

  // ---------------- single-cycle ALU ----------------
  logic [31:0] a, b, add_res, mulh_s, alu_res;
  logic [4:0]  shamt;
  logic [63:0] prod_u;

  assign a       = r.src1;
  assign b       = r.src2;
  assign shamt   = b[4:0];
  assign add_res = a + b;
  assign prod_u  = {32'd0, a} * {32'd0, b};
  // Signed high word recovered from the unsigned product by subtracting the
  // cross terms introduced by two's-complement sign bits.
  assign mulh_s  = prod_u[63:32] - (a[31] ? b : 32'd0) - (b[31] ? a : 32'd0);

  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    alu_res = '0;
    case (1'b1)
      r.alu_op[0]:  alu_res = add_res;
      r.alu_op[1]:  alu_res = a - b;
      r.alu_op[2]:  alu_res = {31'd0, $signed(a) < $signed(b)};
      r.alu_op[3]:  alu_res = {31'd0, a < b};
      r.alu_op[4]:  alu_res = a & b;
      r.alu_op[5]:  alu_res = ~(a | b);
      r.alu_op[6]:  alu_res = a | b;
      r.alu_op[7]:  alu_res = a ^ b;
      r.alu_op[8]:  alu_res = a << shamt;
      r.alu_op[9]:  alu_res = a >> shamt;
      r.alu_op[10]: alu_res = $unsigned($signed(a) >>> shamt);
      r.alu_op[11]: alu_res = b;
      r.alu_op[12]: alu_res = prod_u[31:0];
      r.alu_op[13]: alu_res = mulh_s;
      r.alu_op[14]: alu_res = prod_u[63:32];
      default:      alu_res = '0;
    endcase
  end

  // ---------------- iterative divider ----------------
  div_state_e  state, state_nx;
  logic [4:0]  cnt;
  logic [31:0] quo, rem, dvs, s1_abs, s2_abs, q_fix, r_fix, div_res;
  logic [32:0] trial, diff;
  logic        is_div, div_signed, div_start, fits;

  assign is_div     = |r.alu_op[18:15];
  assign div_signed = r.alu_op[15] | r.alu_op[17];
  assign div_start  = exe_valid & is_div & (state == IDLE);
  assign s1_abs     = (div_signed & a[31]) ? (~a + 32'd1) : a;
  assign s2_abs     = (div_signed & b[31]) ? (~b + 32'd1) : b;
  assign trial      = {rem, quo[31]};
  assign diff       = trial - {1'b0, dvs};
  assign fits       = ~diff[32];

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (div_start) state_nx = BUSY;
      BUSY:    if (cnt == 5'd31) state_nx = DONE;
      DONE:    if (exe_valid && exe_ready_go && pipe.MEM_allow_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn)              cnt <= '0;
    else if (div_start)       cnt <= '0;
    else if (state == BUSY)   cnt <= cnt + 5'd1;
  end

  // Restoring division: shift one dividend bit into the partial remainder
  // and keep the subtraction whenever it does not borrow.
  always_ff @(posedge clk) begin
    if (div_start) begin
      quo <= s1_abs;
      dvs <= s2_abs;
      rem <= '0;
    end else if (state == BUSY) begin
      quo <= {quo[30:0], fits};
      rem <= fits ? diff[31:0] : trial[31:0];
    end
  end

  assign q_fix   = (div_signed & (a[31] ^ b[31])) ? (~quo + 32'd1) : quo;
  assign r_fix   = (div_signed & a[31]) ? (~rem + 32'd1) : rem;
  assign div_res = (r.alu_op[15] | r.alu_op[16]) ? q_fix : r_fix;

  // ---------------- outputs ----------------
  assign exe_ready_go = ~is_div | (state == DONE);
  assign exe_result   = is_div ? div_res : alu_res;

  assign pipe.EXE_allow_in     = allow_in;
  assign pipe.EXE_to_MEM_valid = exe_valid & exe_ready_go;
  assign pipe.EXE_to_MEM_bus   = {r.res_from_mem, r.gr_we, r.dest, exe_result, r.pc};

  assign pipe.EXE_wr_bus = {
    exe_valid & r.gr_we & (r.dest != 5'd0),
    exe_valid & r.gr_we & (r.res_from_mem | (is_div & (state != DONE))),
    r.dest,
    exe_result
  };

  assign pipe.data_sram_en    = exe_valid & (r.res_from_mem | r.mem_we);
  assign pipe.data_sram_we    = {4{exe_valid & r.mem_we}};
  assign pipe.data_sram_addr  = add_res;
  assign pipe.data_sram_wdata = r.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: expected results are queued at issue and
// compared when the stage hands an instruction to MEM.
module tb_exe_stage;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exe_stage_if bus_if ();

  exe_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .pipe   (bus_if)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    bit          care;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] pc_ctr = 32'h1c00_0000;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model written independently of the RTL datapath.
  function automatic logic [31:0] model(int op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic [63:0]        ext;
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    pu  = {32'd0, a} * {32'd0, b};
    ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    ext = {{32{a[31]}}, a} >> b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return (sa < sbv) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << b[4:0];
      9:  return a >> b[4:0];
      10: return ext[31:0];
      11: return b;
      12: return pu[31:0];
      13: return ps[63:32];
      14: return pu[63:32];
      15: begin
        if (b == 0) return 32'd0;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'h8000_0000;
        return sa / sbv;
      end
      16: return (b == 0) ? 32'd0 : a / b;
      17: begin
        if (b == 0) return 32'd0;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'd0;
        return sa % sbv;
      end
      18: return (b == 0) ? 32'd0 : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction, holds it until EXE accepts it, returns in cycle T.
  task automatic issue(int op, logic [31:0] a, logic [31:0] b, logic rfm, logic gw,
                       logic mw, logic [4:0] dest, logic [31:0] rkd, bit care);
    exp_t        e;
    logic [18:0] oh;
    bit          acc;
    int          n;
    oh     = 19'd1 << op;
    e.pc   = pc_ctr;
    e.res  = model(op, a, b);
    e.care = care;
    bus_if.ID_to_EXE_bus   = {oh, a, b, rfm, gw, mw, dest, rkd, pc_ctr, 32'h0};
    bus_if.ID_to_EXE_valid = 1'b1;
    sb.push_back(e);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus_if.EXE_allow_in;
      next_cycle();
      n++;
    end
    bus_if.ID_to_EXE_valid = 1'b0;
    pc_ctr += 32'd4;
    check("issue_accept", acc, 1'b1);
  endtask

  // Counts negedges from cycle T until EXE_to_MEM_valid; cyc = -1 on timeout.
  task automatic wait_ready(output int cyc, output bit load_all);
    load_all = 1'b1;
    cyc      = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.EXE_to_MEM_valid) begin
        cyc = i;
        break;
      end
      if (!bus_if.EXE_wr_bus[37]) load_all = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (resetn && bus_if.EXE_to_MEM_valid && bus_if.MEM_allow_in) begin
      check("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("out_pc", bus_if.EXE_to_MEM_bus[31:0], mon_e.pc);
        if (mon_e.care) check("out_result", bus_if.EXE_to_MEM_bus[63:32], mon_e.res);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int  cyc;
    bit  load_all;
    logic [31:0] ra, rb;

    bus_if.ID_to_EXE_valid = 1'b0;
    bus_if.ID_to_EXE_bus   = '0;
    bus_if.MEM_allow_in    = 1'b1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_allow_in", bus_if.EXE_allow_in, 1'b1);
    check("rst_to_mem_valid", bus_if.EXE_to_MEM_valid, 1'b0);
    check("rst_sram_en", bus_if.data_sram_en, 1'b0);
    check("rst_sram_we", bus_if.data_sram_we, 4'h0);
    check("rst_write", bus_if.EXE_wr_bus[38], 1'b0);
    check("rst_load", bus_if.EXE_wr_bus[37], 1'b0);
    next_cycle();
    resetn = 1'b1;
    next_cycle();

    // add.w 5 + 7
    issue(0, 32'd5, 32'd7, 1'b0, 1'b1, 1'b0, 5'd3, 32'd0, 1'b1);
    @(negedge clk);
    check("add_valid", bus_if.EXE_to_MEM_valid, 1'b1);
    check("add_write", bus_if.EXE_wr_bus[38], 1'b1);
    check("add_fwd", bus_if.EXE_wr_bus[31:0], 32'd12);
    next_cycle();

    // st.w
    issue(0, 32'h1000, 32'd8, 1'b0, 1'b0, 1'b1, 5'd0, 32'hdeadbeef, 1'b1);
    @(negedge clk);
    check("st_en", bus_if.data_sram_en, 1'b1);
    check("st_we", bus_if.data_sram_we, 4'hf);
    check("st_addr", bus_if.data_sram_addr, 32'h1008);
    check("st_wdata", bus_if.data_sram_wdata, 32'hdeadbeef);
    check("st_write", bus_if.EXE_wr_bus[38], 1'b0);
    next_cycle();

    // mulh.w then mulh.wu to r0, back to back
    issue(13, 32'h8000_0000, 32'd2, 1'b0, 1'b1, 1'b0, 5'd5, 32'd0, 1'b1);
    issue(14, 32'h8000_0000, 32'd2, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    @(negedge clk);
    check("mulhu_r0_write", bus_if.EXE_wr_bus[38], 1'b0);
    check("mulhu_fwd", bus_if.EXE_wr_bus[31:0], 32'd1);
    next_cycle();

    // streamed single-cycle ops with random operands
    for (int op = 0; op <= 14; op++) begin
      for (int k = 0; k < 2; k++) begin
        issue(op, $urandom, $urandom, 1'b0, 1'b1, 1'b0, 5'($urandom_range(1, 31)), 32'd0, 1'b1);
      end
    end
    repeat (2) next_cycle();

    // div.w -7 / 2 and mod.w -7 % 2
    issue(15, 32'hffff_fff9, 32'd2, 1'b0, 1'b1, 1'b0, 5'd6, 32'd0, 1'b1);
    wait_ready(cyc, load_all);
    check("divw_latency", cyc, 32'd33);
    check("divw_load_busy", load_all, 1'b1);
    check("divw_load_done", bus_if.EXE_wr_bus[37], 1'b0);
    next_cycle();
    issue(17, 32'hffff_fff9, 32'd2, 1'b0, 1'b1, 1'b0, 5'd6, 32'd0, 1'b1);
    wait_ready(cyc, load_all);
    check("modw_latency", cyc, 32'd33);
    next_cycle();

    // div.wu 100 / 7 with MEM stalled at T+33..T+35
    issue(16, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0, 5'd7, 32'd0, 1'b1);
    bus_if.MEM_allow_in = 1'b0;
    wait_ready(cyc, load_all);
    check("divwu_latency", cyc, 32'd33);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_valid", bus_if.EXE_to_MEM_valid, 1'b1);
      check("stall_allow_in", bus_if.EXE_allow_in, 1'b0);
      check("stall_result", bus_if.EXE_to_MEM_bus[63:32], 32'd14);
    end
    next_cycle();
    bus_if.MEM_allow_in = 1'b1;
    @(negedge clk);
    check("stall_release_allow_in", bus_if.EXE_allow_in, 1'b1);
    next_cycle();

    // overflow corner: 0x80000000 / -1
    issue(15, 32'h8000_0000, 32'hffff_ffff, 1'b0, 1'b1, 1'b0, 5'd8, 32'd0, 1'b1);
    wait_ready(cyc, load_all);
    check("ovf_div_latency", cyc, 32'd33);
    next_cycle();
    issue(17, 32'h8000_0000, 32'hffff_ffff, 1'b0, 1'b1, 1'b0, 5'd8, 32'd0, 1'b1);
    wait_ready(cyc, load_all);
    check("ovf_mod_latency", cyc, 32'd33);
    next_cycle();

    // divide by zero: value unspecified, must still finish on time
    issue(16, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 5'd9, 32'd0, 1'b0);
    wait_ready(cyc, load_all);
    check("div0_latency", cyc, 32'd33);
    next_cycle();

    // random divides and remainders
    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = 32'($urandom_range(1, 5000));
      if (k % 2 == 0 && $urandom_range(0, 1) == 1) rb = -rb;
      issue(15 + k, ra, rb, 1'b0, 1'b1, 1'b0, 5'd10, 32'd0, 1'b1);
      wait_ready(cyc, load_all);
      check("rand_div_latency", cyc, 32'd33);
      next_cycle();
    end

    // back-to-back divides: second starts only after the first leaves
    issue(16, 32'd1000, 32'd9, 1'b0, 1'b1, 1'b0, 5'd11, 32'd0, 1'b1);
    issue(18, 32'd1000, 32'd9, 1'b0, 1'b1, 1'b0, 5'd12, 32'd0, 1'b1);
    wait_ready(cyc, load_all);
    check("b2b_second_latency", cyc, 32'd33);
    next_cycle();

    // reset at T+10 of a divide aborts it
    issue(16, 32'd77, 32'd3, 1'b0, 1'b1, 1'b0, 5'd13, 32'd0, 1'b1);
    repeat (10) @(negedge clk);
    next_cycle();
    resetn = 1'b0;
    next_cycle();
    sb.delete();
    @(negedge clk);
    check("abort_to_mem_valid", bus_if.EXE_to_MEM_valid, 1'b0);
    check("abort_allow_in", bus_if.EXE_allow_in, 1'b1);
    check("abort_load", bus_if.EXE_wr_bus[37], 1'b0);
    next_cycle();
    resetn = 1'b1;
    next_cycle();
    issue(15, 32'hffff_ff9c, 32'd7, 1'b0, 1'b1, 1'b0, 5'd14, 32'd0, 1'b1);
    wait_ready(cyc, load_all);
    check("post_abort_latency", cyc, 32'd33);
    next_cycle();

    repeat (4) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
